// File: rtl/sysarr_nxn.sv
// Purpose: output-stationary NxN systolic multiplier, C = A x B (signed), with a start/feed/flush/drain FSM.
// Latency: N accepted beats + (2N-1) flush cycles, then one result row per accepted out beat; done one cycle after the last row.
// Backpressure: i_in_valid bubbles inject zeros; i_out_ready low holds the current row; accumulators stay frozen while draining.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   begin a new multiply (only honoured in IDLE)
//   i_in_valid / o_in_ready   operand beat handshake; i_a_col lane i = A[i][k], i_b_row lane j = B[k][j]
//   o_out_valid / i_out_ready result row handshake; o_out_data lane j = C[row][j]
//   o_busy, o_done, o_count   status: not idle, end-of-job pulse, phase counter
module sysarr_nxn #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [N*DW-1:0]      i_a_col,
    input  logic [N*DW-1:0]      i_b_row,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [N*ACC_W-1:0]   o_out_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_count
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_clear;
    logic               w_run;
    logic               w_beat;
    logic               w_row_take;
    logic [RW-1:0]      w_row;

    logic [DW-1:0]      w_a   [N][N];
    logic [DW-1:0]      w_b   [N][N];
    logic [ACC_W-1:0]   w_acc [N][N];

    assign w_clear    = (r_state == S_IDLE) && i_start;
    // The array only moves while operands or flush zeros are travelling; it is frozen in IDLE/DRAIN.
    assign w_run      = (r_state == S_FEED) || (r_state == S_FLUSH);
    assign w_beat     = r_in_ready && i_in_valid;
    assign w_row_take = r_out_valid && i_out_ready;
    assign w_row      = r_count[RW-1:0];

    // Control FSM; all handshake/status outputs are registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_FEED;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (w_beat) begin
                        if (r_count == CNT_W'(N - 1)) begin
                            r_state    <= S_FLUSH;
                            r_count    <= '0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Last beat reaches PE(N-1,N-1) 2N-1 edges after acceptance.
                    if (r_count == CNT_W'(2 * N - 2)) begin
                        r_state     <= S_DRAIN;
                        r_count     <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_row_take) begin
                        if (r_count == CNT_W'(N - 1)) begin
                            r_state     <= S_IDLE;
                            r_count     <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Row skew: lane i passes through i+1 registers, so PE(i,0) sees a beat i cycles after PE(0,0).
    for (genvar i = 0; i < N; i++) begin : g_askew
        logic [DW-1:0] r_sk [0:i];
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int s = 0; s <= i; s++) r_sk[s] <= '0;
            end else if (w_clear) begin
                for (int s = 0; s <= i; s++) r_sk[s] <= '0;
            end else if (w_run) begin
                r_sk[0] <= w_beat ? i_a_col[i*DW +: DW] : '0;
                for (int s = 1; s <= i; s++) r_sk[s] <= r_sk[s-1];
            end
        end
        assign w_a[i][0] = r_sk[i];
    end

    // Column skew, same structure along B.
    for (genvar j = 0; j < N; j++) begin : g_bskew
        logic [DW-1:0] r_sk [0:j];
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int s = 0; s <= j; s++) r_sk[s] <= '0;
            end else if (w_clear) begin
                for (int s = 0; s <= j; s++) r_sk[s] <= '0;
            end else if (w_run) begin
                r_sk[0] <= w_beat ? i_b_row[j*DW +: DW] : '0;
                for (int s = 1; s <= j; s++) r_sk[s] <= r_sk[s-1];
            end
        end
        assign w_b[0][j] = r_sk[j];
    end

    // Processing elements: MAC into a local accumulator, forward a right and b down.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [ACC_W-1:0]      r_acc;
            logic signed [2*DW-1:0] w_prod;

            assign w_prod = $signed(w_a[i][j]) * $signed(w_b[i][j]);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_acc <= '0;
                end else if (w_clear) begin
                    r_acc <= '0;
                end else if (w_run) begin
                    // Signed size cast sign-extends the product; the add wraps mod 2^ACC_W.
                    r_acc <= r_acc + ACC_W'(w_prod);
                end
            end
            assign w_acc[i][j] = r_acc;

            if (j < N - 1) begin : g_apass
                logic [DW-1:0] r_a_pass;
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n)     r_a_pass <= '0;
                    else if (w_clear) r_a_pass <= '0;
                    else if (w_run)   r_a_pass <= w_a[i][j];
                end
                assign w_a[i][j+1] = r_a_pass;
            end

            if (i < N - 1) begin : g_bpass
                logic [DW-1:0] r_b_pass;
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n)     r_b_pass <= '0;
                    else if (w_clear) r_b_pass <= '0;
                    else if (w_run)   r_b_pass <= w_b[i][j];
                end
                assign w_b[i+1][j] = r_b_pass;
            end
        end
    end

    // Result row mux; forced to zero whenever no row is being presented.
    always_comb begin
        o_out_data = '0;
        if (r_out_valid) begin
            for (int j = 0; j < N; j++) o_out_data[j*ACC_W +: ACC_W] = w_acc[w_row][j];
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_count     = r_count;

endmodule
